// File: rtl/cpu_controller.sv
// Multi-cycle control FSM for the 10-bit datapath: captures an instruction and
// sequences register-file, ALU-latch and bus-driver controls over 1-3 cycles.
module cpu_controller (
   input  logic       CLKb,
   input  logic       RSTb,
   input  logic       Execute,
   input  logic [9:0] INSTR,
   input  logic [1:0] PeekAddr,
   output logic       IRen,
   output logic       ENW,
   output logic [1:0] WRA,
   output logic       ENR0,
   output logic [1:0] RDA0,
   output logic       ENR1,
   output logic [1:0] RDA1,
   output logic       Ain,
   output logic       Gin,
   output logic       Gout,
   output logic       EXTout,
   output logic [2:0] ALUop,
   output logic       Busy,
   output logic       Done
);

   localparam int unsigned OP_W  = 4;
   localparam int unsigned REG_W = 2;
   localparam int unsigned ALU_W = 3;

   localparam logic [OP_W-1:0] OP_LOAD = 4'b0000;
   localparam logic [OP_W-1:0] OP_COPY = 4'b0001;
   localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
   localparam logic [OP_W-1:0] OP_SUB  = 4'b0011;
   localparam logic [OP_W-1:0] OP_INV  = 4'b0100;
   localparam logic [OP_W-1:0] OP_FLIP = 4'b0101;
   localparam logic [OP_W-1:0] OP_AND  = 4'b0110;
   localparam logic [OP_W-1:0] OP_OR   = 4'b0111;
   localparam logic [OP_W-1:0] OP_XOR  = 4'b1000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_T1   = 2'd1,
      S_T2   = 2'd2,
      S_T3   = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [OP_W-1:0]    op;
   logic [REG_W-1:0]   rx, ry;
   logic               is_alu, is_two_op;
   logic [ALU_W-1:0]   alu_code;
   logic               unused_instr_lsbs;

   assign unused_instr_lsbs = ^INSTR[1:0];

   // State register and instruction-field capture (IDLE only)
   always_ff @(posedge CLKb or negedge RSTb) begin
      if (!RSTb) begin
         state <= S_IDLE;
         op    <= '0;
         rx    <= '0;
         ry    <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && Execute) begin
            op <= INSTR[9:6];
            rx <= INSTR[5:4];
            ry <= INSTR[3:2];
         end
      end
   end

   // Opcode decode
   always_comb begin
      is_alu    = (op >= OP_ADD) && (op <= OP_XOR);
      is_two_op = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                  (op == OP_OR)  || (op == OP_XOR);
      case (op)
         OP_ADD:  alu_code = 3'b000;
         OP_SUB:  alu_code = 3'b001;
         OP_INV:  alu_code = 3'b010;
         OP_FLIP: alu_code = 3'b011;
         OP_AND:  alu_code = 3'b100;
         OP_OR:   alu_code = 3'b101;
         OP_XOR:  alu_code = 3'b110;
         default: alu_code = 3'b000;
      endcase
   end

   // Next state and outputs; outputs settle right after posedge, ahead of the
   // register file's negedge write
   always_comb begin
      state_nxt = state;
      IRen      = 1'b0;
      ENW       = 1'b0;
      WRA       = '0;
      ENR0      = 1'b0;
      RDA0      = '0;
      ENR1      = 1'b1;
      RDA1      = PeekAddr;
      Ain       = 1'b0;
      Gin       = 1'b0;
      Gout      = 1'b0;
      EXTout    = 1'b0;
      ALUop     = '0;
      Busy      = (state != S_IDLE);
      Done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (Execute) begin
               IRen      = 1'b1;
               state_nxt = S_T1;
            end
         end
         S_T1: begin
            if (op == OP_LOAD) begin
               EXTout    = 1'b1;
               ENW       = 1'b1;
               WRA       = rx;
               Done      = 1'b1;
               state_nxt = S_IDLE;
            end else if (op == OP_COPY) begin
               ENR0      = 1'b1;
               RDA0      = ry;
               ENW       = 1'b1;
               WRA       = rx;
               Done      = 1'b1;
               state_nxt = S_IDLE;
            end else if (is_alu) begin
               ENR0      = 1'b1;
               RDA0      = rx;
               Ain       = 1'b1;
               state_nxt = S_T2;
            end else begin
               Done      = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_T2: begin
            ALUop     = alu_code;
            Gin       = 1'b1;
            ENR0      = is_two_op;
            RDA0      = is_two_op ? ry : 2'b00;
            state_nxt = S_T3;
         end
         S_T3: begin
            ALUop     = alu_code;
            Gout      = 1'b1;
            ENW       = 1'b1;
            WRA       = rx;
            Done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: hand-computed control vectors per cycle.
module tb_cpu_controller;

   logic       CLKb = 1'b0;
   logic       RSTb = 1'b0;
   logic       Execute = 1'b0;
   logic [9:0] INSTR = '0;
   logic [1:0] PeekAddr = '0;
   logic       IRen, ENW, ENR0, ENR1, Ain, Gin, Gout, EXTout, Busy, Done;
   logic [1:0] WRA, RDA0, RDA1;
   logic [2:0] ALUop;

   int errors = 0;
   int checks = 0;

   cpu_controller dut (
      .CLKb(CLKb), .RSTb(RSTb), .Execute(Execute), .INSTR(INSTR),
      .PeekAddr(PeekAddr), .IRen(IRen), .ENW(ENW), .WRA(WRA), .ENR0(ENR0),
      .RDA0(RDA0), .ENR1(ENR1), .RDA1(RDA1), .Ain(Ain), .Gin(Gin),
      .Gout(Gout), .EXTout(EXTout), .ALUop(ALUop), .Busy(Busy), .Done(Done)
   );

   always #5 CLKb = ~CLKb;

   // {IRen,ENW,WRA,ENR0,RDA0,ENR1,RDA1,Ain,Gin,Gout,EXTout,ALUop,Busy,Done}
   logic [18:0] obs;
   assign obs = {IRen, ENW, WRA, ENR0, RDA0, ENR1, RDA1, Ain, Gin, Gout,
                 EXTout, ALUop, Busy, Done};

   function automatic logic [18:0] ev(input logic iren, input logic enw,
         input logic [1:0] wra, input logic enr0, input logic [1:0] rda0,
         input logic ain, input logic gin, input logic gout, input logic ext,
         input logic [2:0] alu, input logic busy, input logic done);
      return {iren, enw, wra, enr0, rda0, 1'b1, PeekAddr, ain, gin, gout,
              ext, alu, busy, done};
   endfunction

   task automatic chk(input string tag, input logic [18:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge CLKb);
      #1;
   endtask

   // Runs one ALU instruction from IDLE and checks T1/T2/T3 and the return to IDLE
   task automatic run_alu(input string tag, input logic [9:0] instr,
         input logic [1:0] rx, input logic [1:0] ry, input logic [2:0] alu,
         input logic two);
      INSTR = instr;
      Execute = 1'b1;
      #1;
      chk({tag, "_idle"}, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
      tick();
      Execute = 1'b0;
      chk({tag, "_t1"}, ev(0, 0, 0, 1, rx, 1, 0, 0, 0, 3'b000, 1, 0));
      tick();
      chk({tag, "_t2"}, ev(0, 0, 0, two, two ? ry : 2'b00, 0, 1, 0, 0, alu, 1, 0));
      tick();
      chk({tag, "_t3"}, ev(0, 1, rx, 0, 0, 0, 0, 1, 0, alu, 1, 1));
      tick();
      chk({tag, "_end"}, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
   endtask

   initial begin
      #1;
      chk("reset", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
      PeekAddr = 2'd1;
      #1;
      chk("reset_peek", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
      tick();
      RSTb = 1'b1;
      tick();
      chk("idle_wait", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));

      // LOAD R2
      INSTR = 10'b0000_10_00_00;
      Execute = 1'b1;
      #1;
      chk("load_idle", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
      tick();
      Execute = 1'b0;
      INSTR = 10'b0011_11_11_00;
      chk("load_t1", ev(0, 1, 2'd2, 0, 0, 0, 0, 0, 1, 3'b000, 1, 1));
      tick();
      chk("load_end", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));

      // COPY R1 <- R3
      INSTR = 10'b0001_01_11_00;
      Execute = 1'b1;
      tick();
      Execute = 1'b0;
      chk("copy_t1", ev(0, 1, 2'd1, 1, 2'd3, 0, 0, 0, 0, 3'b000, 1, 1));
      tick();
      chk("copy_end", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));

      run_alu("sub",  10'b0011_00_01_00, 2'd0, 2'd1, 3'b001, 1'b1);
      run_alu("inv",  10'b0100_11_10_00, 2'd3, 2'd2, 3'b010, 1'b0);
      run_alu("flip", 10'b0101_01_11_00, 2'd1, 2'd3, 3'b011, 1'b0);
      run_alu("and",  10'b0110_10_10_00, 2'd2, 2'd2, 3'b100, 1'b1);
      run_alu("or",   10'b0111_01_00_00, 2'd1, 2'd0, 3'b101, 1'b1);

      // Illegal opcode: one-cycle NOP with Done and no write
      INSTR = 10'b1111_10_10_10;
      Execute = 1'b1;
      tick();
      Execute = 1'b0;
      chk("ill_t1", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 1));
      tick();
      chk("ill_end", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));

      // Execute held: ADD R1,R2 then XOR R3,R0; INSTR changes while busy
      PeekAddr = 2'd2;
      INSTR = 10'b0010_01_10_00;
      Execute = 1'b1;
      #1;
      chk("hold_idle", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
      tick();
      chk("hold_add_t1", ev(0, 0, 0, 1, 2'd1, 1, 0, 0, 0, 3'b000, 1, 0));
      INSTR = 10'b1000_11_00_00;
      tick();
      chk("hold_add_t2", ev(0, 0, 0, 1, 2'd2, 0, 1, 0, 0, 3'b000, 1, 0));
      tick();
      chk("hold_add_t3", ev(0, 1, 2'd1, 0, 0, 0, 0, 1, 0, 3'b000, 1, 1));
      tick();
      chk("hold_gap", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
      tick();
      Execute = 1'b0;
      chk("hold_xor_t1", ev(0, 0, 0, 1, 2'd3, 1, 0, 0, 0, 3'b000, 1, 0));
      tick();
      chk("hold_xor_t2", ev(0, 0, 0, 1, 2'd0, 0, 1, 0, 0, 3'b110, 1, 0));
      tick();
      chk("hold_xor_t3", ev(0, 1, 2'd3, 0, 0, 0, 0, 1, 0, 3'b110, 1, 1));
      tick();
      chk("hold_end", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));

      // Reset during T2 of ADD R2,R3
      INSTR = 10'b0010_10_11_00;
      Execute = 1'b1;
      tick();
      Execute = 1'b0;
      tick();
      chk("rst_pre_t2", ev(0, 0, 0, 1, 2'd3, 0, 1, 0, 0, 3'b000, 1, 0));
      #1;
      RSTb = 1'b0;
      #1;
      chk("rst_async", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
      tick();
      chk("rst_held", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
      #2;
      RSTb = 1'b1;
      tick();
      chk("rst_after1", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
      tick();
      chk("rst_after2", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
